lu_result_buffer: RTL and testbench

- Sits directly downstream of logical_unit in the execute stage and feeds register-file writeback.
- Captures each logical-unit result with its opcode and destination register.
- Computes the zero, negative and parity flags at capture time.
- Buffers up to two results in a valid/ready skid buffer, so the execute stage keeps issuing while writeback stalls.
- Counts writeback stall cycles for performance debug.

---
 rtl/lu_result_buffer_if.sv | 40 ++++
 rtl/lu_result_buffer.sv | 119 +++++++++++
 tb/tb_lu_result_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/lu_result_buffer_if.sv
// lu_result_buffer_if
//   Bundles the handshake and data signals around lu_result_buffer.
//   Upstream side (execute stage -> buffer):
//     in_valid, in_ready, in_opcode, in_dest, in_result
//   Downstream side (buffer -> register-file writeback):
//     out_valid, out_ready, out_opcode, out_dest, out_result, out_flags
//   Handshake rule for both sides: a transfer happens on a rising clk edge
//   where valid and ready are both 1. A producer holds valid and its data
//   stable until that transfer. in_ready never depends on out_ready.
//   Modports:
//     slave  - the buffer itself
//     master - the surrounding logic (execute stage plus writeback)
interface lu_result_buffer_if #(
    parameter int WORD_SIZE   = 19,
    parameter int OPCODE_SIZE = 5,
    parameter int REG_ADDR_W  = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OPCODE_SIZE-1:0] in_opcode;
    logic [REG_ADDR_W-1:0]  in_dest;
    logic [WORD_SIZE-1:0]   in_result;

    logic                   out_valid;
    logic                   out_ready;
    logic [OPCODE_SIZE-1:0] out_opcode;
    logic [REG_ADDR_W-1:0]  out_dest;
    logic [WORD_SIZE-1:0]   out_result;
    logic [2:0]             out_flags;

    modport slave (
        input  in_valid, in_opcode, in_dest, in_result, out_ready,
        output in_ready, out_valid, out_opcode, out_dest, out_result, out_flags
    );

    modport master (
        output in_valid, in_opcode, in_dest, in_result, out_ready,
        input  in_ready, out_valid, out_opcode, out_dest, out_result, out_flags
    );
endinterface

// File: rtl/lu_result_buffer.sv
// lu_result_buffer
//   Two-entry FIFO skid buffer between logical_unit and register-file
//   writeback. Each entry stores {opcode, dest, result, flags}; the flags
//   {Z, N, P} are computed from the result as it is pushed. Also counts
//   writeback stall cycles (saturating) for performance debug.
//   Ports:
//     clk          - system clock, rising edge
//     rst          - synchronous active-high reset, highest priority
//     flush        - synchronous discard of all buffered entries
//     bus          - lu_result_buffer_if.slave (in_* upstream, out_* downstream)
//     occupancy    - number of valid entries, 0..2
//     stall_cycles - edges with out_valid=1 and out_ready=0, saturating
module lu_result_buffer #(
    parameter int WORD_SIZE   = 19,
    parameter int OPCODE_SIZE = 5,
    parameter int REG_ADDR_W  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    lu_result_buffer_if.slave      bus,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    logic [OPCODE_SIZE-1:0] opc_q  [2];
    logic [OPCODE_SIZE-1:0] opc_d  [2];
    logic [REG_ADDR_W-1:0]  dest_q [2];
    logic [REG_ADDR_W-1:0]  dest_d [2];
    logic [WORD_SIZE-1:0]   res_q  [2];
    logic [WORD_SIZE-1:0]   res_d  [2];
    logic [2:0]             flg_q  [2];
    logic [2:0]             flg_d  [2];

    logic                   head_q, head_d;
    logic [1:0]             count_q, count_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic push, pop, wr_slot;
    logic [2:0] in_flags;

    // in_ready looks only at registered state plus rst/flush, so writeback
    // back-pressure never forms a combinational path to the execute stage.
    assign bus.in_ready  = !rst && !flush && (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Pushes only happen with count 0 or 1, so head+count mod 2 is an XOR.
    assign wr_slot  = head_q ^ count_q[0];
    assign in_flags = {~|bus.in_result, bus.in_result[WORD_SIZE-1], ^bus.in_result};

    assign bus.out_opcode = opc_q[head_q];
    assign bus.out_dest   = dest_q[head_q];
    assign bus.out_result = res_q[head_q];
    assign bus.out_flags  = flg_q[head_q];
    assign occupancy      = count_q;
    assign stall_cycles   = stall_q;

    always_comb begin
        opc_d   = opc_q;
        dest_d  = dest_q;
        res_d   = res_q;
        flg_d   = flg_q;
        head_d  = head_q;
        count_d = count_q;
        stall_d = stall_q;

        if (push) begin
            opc_d[wr_slot]  = bus.in_opcode;
            dest_d[wr_slot] = bus.in_dest;
            res_d[wr_slot]  = bus.in_result;
            flg_d[wr_slot]  = in_flags;
        end

        if (pop) begin
            head_d = ~head_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Flush drops everything but leaves entry contents in place; the
        // stall counter keeps its history across a flush.
        if (flush) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end

        if (bus.out_valid && !bus.out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                opc_q[i]  <= '0;
                dest_q[i] <= '0;
                res_q[i]  <= '0;
                flg_q[i]  <= '0;
            end
            head_q  <= 1'b0;
            count_q <= 2'd0;
            stall_q <= '0;
        end else begin
            opc_q   <= opc_d;
            dest_q  <= dest_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            head_q  <= head_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_lu_result_buffer.sv
module tb_lu_result_buffer;
    localparam int WORD_SIZE   = 19;
    localparam int OPCODE_SIZE = 5;
    localparam int REG_ADDR_W  = 4;
    localparam int STALL_CNT_W = 16;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic [1:0]             occupancy;
    logic [STALL_CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    lu_result_buffer_if #(
        .WORD_SIZE(WORD_SIZE), .OPCODE_SIZE(OPCODE_SIZE), .REG_ADDR_W(REG_ADDR_W)
    ) bus ();

    lu_result_buffer #(
        .WORD_SIZE(WORD_SIZE), .OPCODE_SIZE(OPCODE_SIZE),
        .REG_ADDR_W(REG_ADDR_W), .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .bus(bus.slave),
        .occupancy(occupancy),
        .stall_cycles(stall_cycles)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge, then settle away from it before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_in(input logic v, input logic [4:0] opc, input logic [3:0] dst,
                            input logic [18:0] res);
        bus.in_valid  = v;
        bus.in_opcode = opc;
        bus.in_dest   = dst;
        bus.in_result = res;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 5'd0, 4'd0, 19'h0);
        tick();
        tick();

        // reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_out_result", 32'(bus.out_result), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // single push of AND result
        drive_in(1'b1, 5'd1, 4'd3, 19'h44444);
        tick();
        drive_in(1'b0, 5'd0, 4'd0, 19'h0);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_result", 32'(bus.out_result), 32'h44444);
        chk("t1_dest", 32'(bus.out_dest), 32'd3);
        chk("t1_opcode", 32'(bus.out_opcode), 32'd1);
        chk("t1_flags", 32'(bus.out_flags), 32'b011);
        chk("t1_occ", 32'(occupancy), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("t1_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_drain_occ", 32'(occupancy), 32'd0);
        chk("t1_stall", 32'(stall_cycles), 32'd0);

        // XOR then NOT-of-all-ones (zero); second push overlaps the first pop
        drive_in(1'b1, 5'd2, 4'd5, 19'h33333);
        tick();
        chk("t2a_result", 32'(bus.out_result), 32'h33333);
        chk("t2a_flags", 32'(bus.out_flags), 32'b000);
        chk("t2a_dest", 32'(bus.out_dest), 32'd5);
        drive_in(1'b1, 5'd3, 4'd6, 19'h00000);
        tick();
        drive_in(1'b0, 5'd0, 4'd0, 19'h0);
        chk("t2b_occ", 32'(occupancy), 32'd1);
        chk("t2b_result", 32'(bus.out_result), 32'h0);
        chk("t2b_flags", 32'(bus.out_flags), 32'b100);
        chk("t2b_dest", 32'(bus.out_dest), 32'd6);
        tick();
        chk("t2_drain_occ", 32'(occupancy), 32'd0);

        // fill to 2 under back-pressure, third entry must wait
        bus.out_ready = 1'b0;
        drive_in(1'b1, 5'd1, 4'd1, 19'h00001);
        tick();
        drive_in(1'b1, 5'd1, 4'd2, 19'h00003);
        tick();
        drive_in(1'b1, 5'd1, 4'd4, 19'h00007);
        #1;
        chk("t3_full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_full_occ", 32'(occupancy), 32'd2);
        tick();
        chk("t3_blocked_occ", 32'(occupancy), 32'd2);
        chk("t3_head_a", 32'(bus.out_dest), 32'd1);
        chk("t3_head_a_flags", 32'(bus.out_flags), 32'b001);
        bus.out_ready = 1'b1;
        #1;
        chk("t3_no_ready_path", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t3_pop1_occ", 32'(occupancy), 32'd1);
        chk("t3_head_b", 32'(bus.out_dest), 32'd2);
        chk("t3_head_b_result", 32'(bus.out_result), 32'h3);
        // C is pushed while B pops: occupancy stays 1 and C becomes the head
        tick();
        drive_in(1'b0, 5'd0, 4'd0, 19'h0);
        chk("t4_pushpop_occ", 32'(occupancy), 32'd1);
        chk("t4_head_c", 32'(bus.out_dest), 32'd4);
        chk("t4_head_c_flags", 32'(bus.out_flags), 32'b001);
        tick();
        chk("t3_drain_occ", 32'(occupancy), 32'd0);
        chk("t3_stall", 32'(stall_cycles), 32'd2);

        // stall counter, flush, then reset clears it
        rst = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        drive_in(1'b1, 5'd4, 4'd9, 19'h40000);
        tick();
        drive_in(1'b0, 5'd0, 4'd0, 19'h0);
        chk("t5_flags", 32'(bus.out_flags), 32'b011);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_result", 32'(bus.out_result), 32'h40000);
        end
        chk("t5_stall5", 32'(stall_cycles), 32'd5);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t5_flush_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("t5_flush_occ", 32'(occupancy), 32'd0);
        chk("t5_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_flush_stall", 32'(stall_cycles), 32'd5);
        tick();
        chk("t5_flush_stall_hold", 32'(stall_cycles), 32'd5);
        rst = 1'b1;
        tick();
        chk("t5_rst_stall", 32'(stall_cycles), 32'd0);
        rst = 1'b0;

        // reset with two entries buffered
        drive_in(1'b1, 5'd1, 4'd7, 19'h12345);
        tick();
        drive_in(1'b1, 5'd1, 4'd8, 19'h54321);
        tick();
        drive_in(1'b0, 5'd0, 4'd0, 19'h0);
        chk("t6_occ2", 32'(occupancy), 32'd2);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_occ", 32'(occupancy), 32'd0);
        chk("t6_rst_result", 32'(bus.out_result), 32'd0);
        tick();
        chk("t6_rst_in_ready2", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_post_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("t6_no_stale", 32'(bus.out_valid), 32'd0);
        drive_in(1'b1, 5'd2, 4'd10, 19'h00F00);
        tick();
        drive_in(1'b0, 5'd0, 4'd0, 19'h0);
        chk("t6_new_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_new_result", 32'(bus.out_result), 32'h00F00);
        chk("t6_new_dest", 32'(bus.out_dest), 32'd10);
        tick();
        chk("t6_new_drain", 32'(occupancy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
